// File: rtl/multimode_storage.sv
// multimode_storage
//   Storage block that behaves as a single-register buffer, a LIFO or a FIFO.
//   The mode comes from the one-hot chip enables. Any change of the decoded
//   mode flushes the stored contents.
//
// Parameters
//   DATA_W : data width in bits
//   DEPTH  : number of entries (power of two, >= 2)
//   ADDR_W : pointer width, derived from DEPTH
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst          : asynchronous active-high reset
//   chip_en_buf  : selects BUFFER when it is the only enable high
//   chip_en_lifo : selects LIFO when it is the only enable high
//   chip_en_fifo : selects FIFO when it is the only enable high
//   push / pop   : write / read requests
//   data_in      : write data
//   data_out     : registered read data
//   dout_valid   : pulse, data_out updated by a pop or a buffer load
//   mode         : BUFFER=0, LIFO=1, FIFO=2, INVALID=3
//   count        : occupancy 0..DEPTH
//   full / empty : occupancy flags
//   err          : pulse on an illegal operation
module multimode_storage #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chip_en_buf,
  input  logic              chip_en_lifo,
  input  logic              chip_en_fifo,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              dout_valid,
  output logic [1:0]        mode,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              err
);

  typedef enum logic [1:0] {
    MODE_BUF     = 2'd0,
    MODE_LIFO    = 2'd1,
    MODE_FIFO    = 2'd2,
    MODE_INVALID = 2'd3
  } mode_e;

  localparam logic [ADDR_W:0]   CNT_ZERO = '0;
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ZERO = '0;
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  mode_e             mode_r;
  mode_e             mode_dec_s;
  logic [DATA_W-1:0] data_out_r;
  logic              dout_valid_r;
  logic              err_r;
  logic [ADDR_W:0]   count_r;
  logic              full_r;
  logic              empty_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;

  logic [ADDR_W:0]   count_nxt_s;
  logic [ADDR_W-1:0] wr_ptr_nxt_s;
  logic [ADDR_W-1:0] rd_ptr_nxt_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic              dout_ld_s;
  logic              dout_sel_in_s;
  logic [ADDR_W-1:0] dout_raddr_s;
  logic              dout_valid_nxt_s;
  logic              err_nxt_s;
  logic [ADDR_W-1:0] top_s;
  logic [DATA_W-1:0] dout_nxt_s;

  // Stack top index; when full the low bits are 0 and the subtraction wraps to DEPTH-1.
  assign top_s = count_r[ADDR_W-1:0] - PTR_ONE;

  // Decode the one-hot enables; any other combination is INVALID.
  always_comb begin
    case ({chip_en_buf, chip_en_lifo, chip_en_fifo})
      3'b100:  mode_dec_s = MODE_BUF;
      3'b010:  mode_dec_s = MODE_LIFO;
      3'b001:  mode_dec_s = MODE_FIFO;
      default: mode_dec_s = MODE_INVALID;
    endcase
  end

  // Next-state, memory write and read-out control for the current operation.
  always_comb begin
    count_nxt_s      = count_r;
    wr_ptr_nxt_s     = wr_ptr_r;
    rd_ptr_nxt_s     = rd_ptr_r;
    mem_we_s         = 1'b0;
    mem_waddr_s      = wr_ptr_r;
    dout_ld_s        = 1'b0;
    dout_sel_in_s    = 1'b0;
    dout_raddr_s     = rd_ptr_r;
    dout_valid_nxt_s = 1'b0;
    err_nxt_s        = 1'b0;
    if (mode_dec_s != mode_r) begin
      // Mode change: flush and drop this cycle's request.
      count_nxt_s  = CNT_ZERO;
      wr_ptr_nxt_s = PTR_ZERO;
      rd_ptr_nxt_s = PTR_ZERO;
    end else begin
      case (mode_r)
        MODE_BUF: begin
          if (push) begin
            dout_ld_s        = 1'b1;
            dout_sel_in_s    = 1'b1;
            dout_valid_nxt_s = 1'b1;
          end else begin
            dout_ld_s = 1'b0;
          end
        end
        MODE_FIFO: begin
          case ({push, pop})
            2'b10: begin
              if (!full_r) begin
                mem_we_s     = 1'b1;
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
                count_nxt_s  = count_r + CNT_ONE;
              end else begin
                err_nxt_s = 1'b1;
              end
            end
            2'b01: begin
              if (!empty_r) begin
                dout_ld_s        = 1'b1;
                dout_valid_nxt_s = 1'b1;
                rd_ptr_nxt_s     = rd_ptr_r + PTR_ONE;
                count_nxt_s      = count_r - CNT_ONE;
              end else begin
                err_nxt_s = 1'b1;
              end
            end
            2'b11: begin
              // When full wr_ptr == rd_ptr: the read sees the old entry.
              mem_we_s     = 1'b1;
              wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
              if (!empty_r) begin
                dout_ld_s        = 1'b1;
                dout_valid_nxt_s = 1'b1;
                rd_ptr_nxt_s     = rd_ptr_r + PTR_ONE;
              end else begin
                count_nxt_s = count_r + CNT_ONE;
                err_nxt_s   = 1'b1;
              end
            end
            default: begin
              err_nxt_s = 1'b0;
            end
          endcase
        end
        MODE_LIFO: begin
          case ({push, pop})
            2'b10: begin
              if (!full_r) begin
                mem_we_s    = 1'b1;
                mem_waddr_s = count_r[ADDR_W-1:0];
                count_nxt_s = count_r + CNT_ONE;
              end else begin
                err_nxt_s = 1'b1;
              end
            end
            2'b01: begin
              if (!empty_r) begin
                dout_ld_s        = 1'b1;
                dout_valid_nxt_s = 1'b1;
                dout_raddr_s     = top_s;
                count_nxt_s      = count_r - CNT_ONE;
              end else begin
                err_nxt_s = 1'b1;
              end
            end
            2'b11: begin
              mem_we_s = 1'b1;
              if (!empty_r) begin
                // Old top goes out, new data replaces it in place.
                mem_waddr_s      = top_s;
                dout_ld_s        = 1'b1;
                dout_valid_nxt_s = 1'b1;
                dout_raddr_s     = top_s;
              end else begin
                mem_waddr_s = PTR_ZERO;
                count_nxt_s = CNT_ONE;
                err_nxt_s   = 1'b1;
              end
            end
            default: begin
              err_nxt_s = 1'b0;
            end
          endcase
        end
        default: begin
          err_nxt_s = push | pop;
        end
      endcase
    end
  end

  // Select the value loaded into data_out.
  always_comb begin
    if (dout_sel_in_s) begin
      dout_nxt_s = data_in;
    end else begin
      dout_nxt_s = mem_r[dout_raddr_s];
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= data_in;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r       <= MODE_INVALID;
      count_r      <= CNT_ZERO;
      full_r       <= 1'b0;
      empty_r      <= 1'b1;
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= PTR_ZERO;
      data_out_r   <= '0;
      dout_valid_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      mode_r       <= mode_dec_s;
      count_r      <= count_nxt_s;
      full_r       <= (count_nxt_s == CNT_FULL);
      empty_r      <= (count_nxt_s == CNT_ZERO);
      wr_ptr_r     <= wr_ptr_nxt_s;
      rd_ptr_r     <= rd_ptr_nxt_s;
      dout_valid_r <= dout_valid_nxt_s;
      err_r        <= err_nxt_s;
      if (dout_ld_s) begin
        data_out_r <= dout_nxt_s;
      end
    end
  end

  assign data_out   = data_out_r;
  assign dout_valid = dout_valid_r;
  assign mode       = mode_r;
  assign count      = count_r;
  assign full       = full_r;
  assign empty      = empty_r;
  assign err        = err_r;

endmodule

// File: tb/tb_multimode_storage.sv
// Self-checking bench for multimode_storage (DATA_W=8, DEPTH=8).
// A queue-based reference model tracks the expected contents and outputs.
module tb_multimode_storage;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_buf = 1'b0, en_lifo = 1'b0, en_fifo = 1'b0;
  logic       push = 1'b0, pop = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] data_out;
  logic       dout_valid;
  logic [1:0] mode;
  logic [3:0] count;
  logic       full, empty, err;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0] m_q[$];
  int         m_mode  = 3;
  logic [7:0] m_dout  = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_err   = 1'b0;

  multimode_storage #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .chip_en_buf(en_buf), .chip_en_lifo(en_lifo), .chip_en_fifo(en_fifo),
    .push(push), .pop(pop), .data_in(din),
    .data_out(data_out), .dout_valid(dout_valid), .mode(mode),
    .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_mode  = 3;
    m_dout  = 8'h00;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  // Apply one clock edge's worth of the spec rules to the model.
  task automatic model_step();
    int dec;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if ($countones({en_buf, en_lifo, en_fifo}) != 1) dec = 3;
    else if (en_buf) dec = 0;
    else if (en_lifo) dec = 1;
    else dec = 2;
    if (dec != m_mode) begin
      m_mode = dec;
      m_q.delete();
    end else if (m_mode == 0) begin
      if (push) begin m_dout = din; m_valid = 1'b1; end
    end else if (m_mode == 3) begin
      m_err = push | pop;
    end else if (push && pop) begin
      if (m_q.size() == 0) begin
        m_q.push_back(din);
        m_err = 1'b1;
      end else if (m_mode == 2) begin
        m_dout = m_q.pop_front();
        m_q.push_back(din);
        m_valid = 1'b1;
      end else begin
        m_dout = m_q[m_q.size()-1];
        m_q[m_q.size()-1] = din;
        m_valid = 1'b1;
      end
    end else if (push) begin
      if (m_q.size() == DEPTH) m_err = 1'b1;
      else m_q.push_back(din);
    end else if (pop) begin
      if (m_q.size() == 0) m_err = 1'b1;
      else begin
        m_dout  = (m_mode == 2) ? m_q.pop_front() : m_q.pop_back();
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic set_mode(input int md);
    en_buf  = (md == 0) || (md == 3);
    en_lifo = (md == 1) || (md == 3);
    en_fifo = (md == 2) || (md == 3);
  endtask

  // Drive one request, clock it, sample 1 time unit after the edge.
  task automatic cyc(input logic p, input logic q, input logic [7:0] d);
    push = p;
    pop  = q;
    din  = d;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_mode(2);
    #12;
    n_cmp++;
    if ({mode, count, empty, full, data_out, dout_valid, err} !==
        {2'd3, 4'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got mode=%0d count=%0d empty=%b full=%b dout=%h v=%b err=%b, want 3 0 1 0 00 0 0",
               mode, count, empty, full, data_out, dout_valid, err);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if ({mode, empty, count, err} !== {2'd2, 1'b1, 4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL first_decode: got mode=%0d empty=%b count=%0d err=%b, want 2 1 0 0", mode, empty, count, err);
    end
  endtask

  task automatic test_fifo_wrap();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 1; i <= 8; i++) begin
        cyc(1'b1, 1'b0, 8'(i));
        n_cmp++;
        if (count !== 4'(i)) begin
          n_bad++;
          $display("FAIL fifo_fill_count: got %0d want %0d", count, i);
        end
      end
      n_cmp++;
      if (full !== 1'b1) begin n_bad++; $display("FAIL fifo_full: got %b want 1", full); end
      cyc(1'b1, 1'b0, 8'h99);
      n_cmp++;
      if ({err, count} !== {1'b1, 4'd8}) begin
        n_bad++;
        $display("FAIL fifo_overflow: got err=%b count=%0d want 1 8", err, count);
      end
      for (int i = 1; i <= 8; i++) begin
        cyc(1'b0, 1'b1, 8'h00);
        n_cmp++;
        if ({data_out, dout_valid} !== {8'(i), 1'b1}) begin
          n_bad++;
          $display("FAIL fifo_pop_order: got %h/v%b want %h/v1", data_out, dout_valid, 8'(i));
        end
      end
      n_cmp++;
      if (empty !== 1'b1) begin n_bad++; $display("FAIL fifo_empty: got %b want 1", empty); end
    end
  endtask

  task automatic test_lifo();
    logic [7:0] exp_v [3] = '{8'hB0, 8'hA2, 8'hA1};
    set_mode(1);
    cyc(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if ({mode, count} !== {2'd1, 4'd0}) begin
      n_bad++;
      $display("FAIL lifo_enter: got mode=%0d count=%0d want 1 0", mode, count);
    end
    cyc(1'b1, 1'b0, 8'hA1);
    cyc(1'b1, 1'b0, 8'hA2);
    cyc(1'b1, 1'b0, 8'hA3);
    cyc(1'b1, 1'b1, 8'hB0);
    n_cmp++;
    if ({data_out, count, dout_valid} !== {8'hA3, 4'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL lifo_push_pop: got dout=%h count=%0d v=%b want a3 3 1", data_out, count, dout_valid);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      n_cmp++;
      if ({data_out, dout_valid} !== {exp_v[i], 1'b1}) begin
        n_bad++;
        $display("FAIL lifo_pop: got %h/v%b want %h/v1", data_out, dout_valid, exp_v[i]);
      end
    end
    cyc(1'b0, 1'b1, 8'h00);
    n_cmp++;
    if ({err, data_out, dout_valid} !== {1'b1, 8'hA1, 1'b0}) begin
      n_bad++;
      $display("FAIL lifo_underflow: got err=%b dout=%h v=%b want 1 a1 0", err, data_out, dout_valid);
    end
  endtask

  task automatic test_push_pop();
    set_mode(2);
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i));
    cyc(1'b1, 1'b1, 8'h55);
    n_cmp++;
    if ({data_out, count, err, dout_valid} !== {8'h10, 4'd8, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL fifo_full_push_pop: got dout=%h count=%0d err=%b v=%b want 10 8 0 1",
               data_out, count, err, dout_valid);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      n_cmp++;
      if (data_out !== ((i == 7) ? 8'h55 : 8'(8'h11 + i))) begin
        n_bad++;
        $display("FAIL fifo_drain: got %h at pop %0d", data_out, i);
      end
    end
    cyc(1'b1, 1'b1, 8'h66);
    n_cmp++;
    if ({count, err, dout_valid} !== {4'd1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL fifo_empty_push_pop: got count=%0d err=%b v=%b want 1 1 0", count, err, dout_valid);
    end
  endtask

  task automatic test_mode_change();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'h70 + i));
    n_cmp++;
    if (count !== 4'd5) begin n_bad++; $display("FAIL mc_prefill: got %0d want 5", count); end
    set_mode(1);
    cyc(1'b1, 1'b0, 8'h77);
    n_cmp++;
    if ({mode, count, err} !== {2'd1, 4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL mc_to_lifo: got mode=%0d count=%0d err=%b want 1 0 0", mode, count, err);
    end
    set_mode(3);
    cyc(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if (mode !== 2'd3) begin n_bad++; $display("FAIL mc_invalid: got %0d want 3", mode); end
    cyc(1'b1, 1'b0, 8'h01);
    n_cmp++;
    if ({err, count} !== {1'b1, 4'd0}) begin
      n_bad++;
      $display("FAIL invalid_push: got err=%b count=%0d want 1 0", err, count);
    end
  endtask

  task automatic test_reset_mid();
    set_mode(2);
    cyc(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i));
    cyc(1'b0, 1'b1, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({mode, count, empty, full, data_out, dout_valid, err} !==
        {2'd3, 4'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: got mode=%0d count=%0d empty=%b full=%b dout=%h v=%b err=%b",
               mode, count, empty, full, data_out, dout_valid, err);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc(1'b0, 1'b0, 8'h00);
    n_cmp++;
    if ({mode, count} !== {2'd2, 4'd0}) begin
      n_bad++;
      $display("FAIL reset_redecode: got mode=%0d count=%0d want 2 0", mode, count);
    end
  endtask

  task automatic test_random();
    int seg_bad;
    seg_bad = 0;
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) begin
        if ($urandom_range(0, 7) == 0) {en_buf, en_lifo, en_fifo} = 3'($urandom_range(0, 7));
        else set_mode($urandom_range(0, 2));
      end
      if ((i % 50) < 25)
        cyc($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35, 8'($urandom));
      else
        cyc($urandom_range(0, 99) < 35, $urandom_range(0, 99) < 70, 8'($urandom));
      n_cmp++;
      if ({data_out, dout_valid, err, mode} !== {m_dout, m_valid, m_err, 2'(m_mode)} ||
          int'(count) != m_q.size() || full !== (m_q.size() == DEPTH) ||
          empty !== (m_q.size() == 0)) begin
        n_bad++;
        seg_bad++;
        if (seg_bad <= 10)
          $display("FAIL random_cycle %0d: got dout=%h v=%b err=%b mode=%0d count=%0d full=%b empty=%b; want %h %b %b %0d %0d",
                   i, data_out, dout_valid, err, mode, count, full, empty,
                   m_dout, m_valid, m_err, m_mode, m_q.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fifo_wrap();
    test_lifo();
    test_push_pop();
    test_mode_change();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multimode_storage.md
# multimode_storage

Parametrised storage block that operates as a single-register buffer, a LIFO or a FIFO. The mode is selected by the one-hot chip enables `chip_en_buf`, `chip_en_fifo` and `chip_en_lifo`. It succeeds the fixed 2-bit mode decoder. It adds on-chip storage of configurable width and depth, push/pop handling, flush on mode change, occupancy flags and error reporting. It sits between the producer/consumer interface and the verification scoreboard of the LIFO/FIFO subsystem.

## Interface
- `DATA_W`, 8: data width in bits.
- `DEPTH`, 8: number of storage entries; power of two, ≥ 2.
- `ADDR_W`, $clog2(DEPTH): pointer width (derived, not overridden).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `chip_en_buf`  in  1  selects BUFFER when it is the only enable high.
- `chip_en_lifo`  in  1  selects LIFO when it is the only enable high.
- `chip_en_fifo`  in  1  selects FIFO when it is the only enable high.
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `data_in`  in  DATA_W  write data.
- `data_out`  out  DATA_W  registered read data.
- `dout_valid`  out  1  one-cycle pulse: `data_out` was updated by a successful pop or buffer load.
- `mode`  out  2  current mode: BUFFER=0, LIFO=1, FIFO=2, INVALID=3.
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `err`  out  1  one-cycle pulse on an illegal operation.

## Operation
- **Mode decode** (every edge):
  - exactly one enable high → corresponding mode;
  - any other enable combination → INVALID.
  - The decoded value is loaded into the `mode` register.
- **Mode change** (decoded mode ≠ registered mode) takes priority over all operations:
  - flush: `count`, write/read pointers and stack pointer → 0;
  - `push`/`pop` of that cycle are ignored; `err` = 0;
  - `data_out` is held;
  - the new mode is effective from the next cycle.
- **Operation code** is {`push`,`pop`}: 00 = NIMIC, 10 = PUSH, 01 = POP, 11 = PUSH_POP. Each operation executes under the registered mode.
- **BUFFER:**
  - PUSH or PUSH_POP → `data_out` ← `data_in`, `dout_valid` = 1;
  - POP alone → no effect;
  - `count` stays 0.
- **FIFO:** `wr_ptr`/`rd_ptr` wrap modulo DEPTH.
  - PUSH, not full → write at `wr_ptr`, `count`+1.
  - POP, not empty → `data_out` ← mem[`rd_ptr`], `count`−1.
  - PUSH_POP, not empty → both execute, `count` unchanged; this is legal when full.
  - PUSH_POP, empty → push only, `err` = 1.
- **LIFO:** top of stack is mem[`count`−1].
  - PUSH, not full → write mem[`count`], `count`+1.
  - POP, not empty → `data_out` ← top, `count`−1.
  - PUSH_POP, not empty → `data_out` ← old top, top ← `data_in`, `count` unchanged.
  - PUSH_POP, empty → push only, `err` = 1.
- **Errors** (`err` pulses, storage unchanged):
  - PUSH when full (without pop);
  - POP when empty;
  - any push/pop in INVALID mode.
- `dout_valid` = 1 only for a pop that executed, or for a BUFFER load.

## Timing
- **Reset values:** `mode` = 3 (INVALID), `count` = 0, `empty` = 1, `full` = 0, `data_out` = 0, `dout_valid` = 0, `err` = 0, all pointers 0. Memory contents are undefined.
- **Reset mid-operation:** immediate return to the reset state; the first decode happens on the first edge after `rst` deasserts.
- **Latency:**
  - Request sampled at edge N → `data_out`, `dout_valid`, `err`, `count`, `full` and `empty` are valid after edge N.
  - `full`/`empty` are decoded from the registered `count`, with no extra cycle.
- Write data is readable by a pop issued on the following cycle.
- The enables take one edge to change `mode`. Operations on that edge are dropped.
- There is no backpressure. The producer must observe `full`/`empty`; violations only raise `err`.

## Test plan
- Reset, then `chip_en_fifo` = 1 for one cycle → `mode` = 2, `empty` = 1, `count` = 0, `err` = 0.
- FIFO, DEPTH = 8: push 0x01..0x08 → `full` = 1. A 9th push → `err` pulse, `count` = 8. Pop ×8 → `data_out` 0x01..0x08 in order, each with `dout_valid`. Then `empty` = 1. Repeat 3 times to exercise pointer wrap.
- LIFO: push 0xA1, 0xA2, 0xA3; PUSH_POP with 0xB0 → `data_out` = 0xA3, `count` = 3. Pop ×3 → 0xB0, 0xA2, 0xA1. A 4th pop → `err` = 1, `data_out` holds 0xA1.
- FIFO full, PUSH_POP with 0x55 → oldest entry out, `count` stays 8, `err` = 0. Empty FIFO, PUSH_POP → `count` = 1, `err` = 1.
- Mode change: FIFO holding 5 entries, switch to LIFO while push = 1 → push ignored, `count` = 0, `mode` = 1 after the edge. Assert all three enables → `mode` = 3; a push then raises `err`.
- Assert `rst` while FIFO holds 4 entries mid-pop → all outputs at reset values immediately. After release, `mode` is re-decoded from the enables.
